synapse_current_driver: RTL and testbench
=========================================

# synapse_current_driver

Converts presynaptic spike events into the per-timestep signed synaptic current that drives one LIF neuron core. Address-event (AER) spikes arrive over a valid/ready handshake and are buffered in a small FIFO. Each event looks up its weight in a writable weight table and is accumulated. On each timestep tick the block drains pending events, publishes the saturated sum on `i_syn_o`, and pulses `step_o`, which is the neuron's clock enable.

## Interface
- `N_PRE`, 16: number of presynaptic sources; the weight table has this many entries.
- `WEIGHT_W`, 16: signed weight width and `i_syn_o` width.
- `ACC_W`, 24: signed accumulator width, must be greater than `WEIGHT_W`.
- `FIFO_DEPTH`, 8: depth of the event FIFO, a power of 2.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `ev_valid_i`  in  1: a spike event is offered.
- `ev_ready_o`  out  1: the block can accept an event.
- `ev_addr_i`  in  $clog2(N_PRE): presynaptic ID of the event.
- `tick_i`  in  1: one-cycle timestep-boundary strobe.
- `wr_en_i`  in  1: weight table write enable.
- `wr_addr_i`  in  $clog2(N_PRE): weight address to write.
- `wr_data_i`  in  WEIGHT_W signed: weight value to write.
- `i_syn_o`  out  WEIGHT_W signed: published synaptic current, held between steps.
- `step_o`  out  1: one-cycle clock enable to the neuron core.
- `sat_o`  out  1: saturation occurred during the published step; valid while `step_o` is high and held until the next publish.
- `tick_miss_o`  out  8: count of ticks ignored because a step was still in progress; saturates at 255.

## Operation
- **Event acceptance**
  - An event is accepted on an edge where `ev_valid_i && ev_ready_o`.
  - `ev_ready_o = !fifo_full && state==RUN`.
- **Pipeline**
  - P0: pop the FIFO when it is non-empty and the state is RUN or DRAIN. The weight read is combinational from the flop table and is registered into `w_q`/`w_vld`.
  - P1: when `w_vld`, `acc <= sat_ACC(acc + sext(w_q))`. If clamping occurs, set `sat_flag`.
- **States**
  - RUN
    - Accept and accumulate events.
    - If `tick_i` is sampled high, go to DRAIN.
  - DRAIN
    - No new events are accepted; the FIFO and pipeline continue to empty.
    - When the FIFO is empty, `w_vld==0`, and no P1 update is pending, go to PUB.
  - PUB (one cycle, then back to RUN)
    - `i_syn_o <= sat_WEIGHT_W(acc)`.
    - `sat_o <= sat_flag || output clamp`.
    - `step_o <= 1`.
    - `acc <= 0` and `sat_flag <= 0`.
- **Tick in DRAIN or PUB:** the tick is ignored and `tick_miss_o` increments, saturating at 255.
- **Saturation**
  - Both saturations clamp to the signed range of the target width: `ACC_W` for the accumulator and `WEIGHT_W` for `i_syn_o`.
  - Overflow never wraps.
- **Weight write**
  - The write takes effect at the edge.
  - A P0 read of the same address in the same cycle returns the old value.
  - Writes are allowed in any state.
- **Out-of-range address:** if `ev_addr_i >= N_PRE`, the event is accepted and contributes 0.

## Timing
- **Reset values**
  - `ev_ready_o` is 0 while `rst` is high, then 1 in the first cycle after release (state RUN, FIFO empty).
  - `i_syn_o=0`, `step_o=0`, `sat_o=0`, `tick_miss_o=0`.
  - Weight table is all 0, `acc=0`.
- **Reset mid-operation:** the FIFO, pipeline and accumulator are discarded and the weights are cleared.
- **Event latency:** an event accepted at edge k is popped at k+1 and accumulated at k+2 if the FIFO was empty.
- **Tick latency, idle block:** tick sampled at edge k puts the block in DRAIN. Edge k+1 enters PUB, and PUB's updates register at edge k+2. `step_o` is high between edges k+2 and k+3, and the block is back in RUN after k+2.
- **Tick latency with pending events:** add one cycle per queued FIFO entry, plus the pipeline drain.
- **Simultaneous tick and event:** an event accepted on the same edge that `tick_i` is sampled counts toward the current step.
- **`step_o`:** never high in two consecutive cycles. `i_syn_o` changes only on the edge that raises `step_o`.

## Structure
- Package `snn_pkg`:
  - `drv_state_e` enum {RUN, DRAIN, PUB}.
  - Default width constants.
  - Function `sat_signed(value, width)`.
- Submodule `syn_event_fifo`: synchronous FIFO, parameterised on width and depth, with `full`/`empty` outputs and simultaneous push/pop support.
- The top level holds the weight table, the P0/P1 pipeline, the FSM and the counters.

## Test plan
- **Basic sum:** `w[3]=100`, `w[5]=-30`; events 3, 3, 5, then tick -> one `step_o` pulse, `i_syn_o=170`, `sat_o=0`.
- **Empty step:** tick with no events -> `step_o` high between edges k+2 and k+3, `i_syn_o=0`.
- **Saturation:** `w[0]=32767`; 4 events, then tick -> `i_syn_o=32767`, `sat_o=1`; next empty step -> `i_syn_o=0`, `sat_o=0`.
- **Backpressure:** hold `ev_valid_i` (addr 1, `w=10`) across a tick -> `ev_ready_o=0` in DRAIN and PUB; no event is lost; the held event appears in the next step's sum.
- **Tick overrun:** second tick while in DRAIN -> ignored, `tick_miss_o=1`, exactly one `step_o` pulse.
- **Reset mid-DRAIN:** assert `rst` with 3 queued events -> all outputs 0; next step publishes 0.

Source files
------------

// File: rtl/snn_pkg.sv
// snn_pkg
// Shared types and helpers for the spiking-network datapath blocks.
//   drv_state_e : synaptic current driver step state (RUN / DRAIN / PUB)
//   *_DEF       : default widths and sizes used by the driver
//   sat_signed  : clamp a wide signed value into the signed range of 'width' bits
package snn_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    PUB   = 2'd2
  } drv_state_e;

  localparam int N_PRE_DEF      = 16;
  localparam int WEIGHT_W_DEF   = 16;
  localparam int ACC_W_DEF      = 24;
  localparam int FIFO_DEPTH_DEF = 8;

  // Callers truncate the result to 'width' bits; comparing the result with the
  // input tells them whether clamping took place.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/syn_event_fifo.sv
// syn_event_fifo
// Small synchronous FIFO for spike addresses. Read data is presented
// combinationally from the head entry; push and pop may happen together.
//   clk, rst : clock, asynchronous active-high reset (discards contents)
//   push/din : write an entry (ignored when full)
//   pop/dout : remove the head entry (ignored when empty), dout is the head
//   full     : DEPTH entries stored
//   empty    : no entries stored
module syn_event_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage is not reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/synapse_current_driver.sv
// synapse_current_driver
// Turns AER spike events into a per-timestep saturated synaptic current for
// one LIF neuron core. Events are queued, weighted through a writable table,
// accumulated, and published once per timestep tick.
//   clk, rst                      : clock, asynchronous active-high reset
//   ev_valid_i/ev_ready_o/ev_addr_i : spike event handshake and source ID
//   tick_i                        : timestep boundary strobe
//   wr_en_i/wr_addr_i/wr_data_i   : weight table write port
//   i_syn_o                       : published current, held between steps
//   step_o                        : one-cycle neuron clock enable
//   sat_o                         : saturation seen in the published step
//   tick_miss_o                   : ticks ignored while a step was busy (sat 255)
module synapse_current_driver
  import snn_pkg::*;
#(
  parameter int N_PRE      = N_PRE_DEF,
  parameter int WEIGHT_W   = WEIGHT_W_DEF,
  parameter int ACC_W      = ACC_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ev_valid_i,
  output logic                       ev_ready_o,
  input  logic [$clog2(N_PRE)-1:0]   ev_addr_i,
  input  logic                       tick_i,
  input  logic                       wr_en_i,
  input  logic [$clog2(N_PRE)-1:0]   wr_addr_i,
  input  logic signed [WEIGHT_W-1:0] wr_data_i,
  output logic signed [WEIGHT_W-1:0] i_syn_o,
  output logic                       step_o,
  output logic                       sat_o,
  output logic [7:0]                 tick_miss_o
);

  localparam int AW = $clog2(N_PRE);

  drv_state_e state;
  drv_state_e next_state;

  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       push;
  logic                       pop;
  logic [AW-1:0]              fifo_dout;
  logic signed [WEIGHT_W-1:0] weights [N_PRE];
  logic signed [WEIGHT_W-1:0] w_rd;
  logic signed [WEIGHT_W-1:0] w_q;
  logic                       w_vld;
  logic                       wr_ok;
  logic signed [ACC_W-1:0]    acc;
  logic                       sat_flag;
  logic signed [63:0]         acc_sum;
  logic signed [63:0]         acc_sat;
  logic signed [63:0]         out_sat;
  logic                       acc_clamp;
  logic                       out_clamp;

  // Ready is forced low during reset so nothing is offered a handshake then.
  assign ev_ready_o = !rst && !fifo_full && (state == RUN);
  assign push       = ev_valid_i && ev_ready_o;
  assign pop        = !fifo_empty && ((state == RUN) || (state == DRAIN));
  assign wr_ok      = int'(wr_addr_i) < N_PRE;

  syn_event_fifo #(
    .WIDTH (AW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (ev_addr_i),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Out-of-range sources are still accepted but contribute nothing.
  always_comb begin
    w_rd = '0;
    if (int'(fifo_dout) < N_PRE) begin
      w_rd = weights[fifo_dout];
    end
  end

  // Weight table; a same-cycle read of the written entry sees the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_PRE; i++) begin
        weights[i] <= '0;
      end
    end else if (wr_en_i && wr_ok) begin
      weights[wr_addr_i] <= wr_data_i;
    end
  end

  // Saturating arithmetic is done at 64 bits so neither sum can wrap.
  always_comb begin
    acc_sum   = 64'(acc) + 64'(w_q);
    acc_sat   = sat_signed(acc_sum, ACC_W);
    acc_clamp = (acc_sat != acc_sum);
    out_sat   = sat_signed(64'(acc), WEIGHT_W);
    out_clamp = (out_sat != 64'(acc));
  end

  // P0: capture the popped event's weight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q   <= '0;
      w_vld <= 1'b0;
    end else begin
      w_vld <= pop;
      if (pop) begin
        w_q <= w_rd;
      end
    end
  end

  // P1: accumulate; PUB clears the step's sum after it has been published.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      sat_flag <= 1'b0;
    end else if (state == PUB) begin
      acc      <= '0;
      sat_flag <= 1'b0;
    end else if (w_vld) begin
      acc <= acc_sat[ACC_W-1:0];
      if (acc_clamp) begin
        sat_flag <= 1'b1;
      end
    end
  end

  // Published outputs only move on the edge that raises step_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_syn_o <= '0;
      sat_o   <= 1'b0;
      step_o  <= 1'b0;
    end else begin
      step_o <= (state == PUB);
      if (state == PUB) begin
        i_syn_o <= out_sat[WEIGHT_W-1:0];
        sat_o   <= sat_flag || out_clamp;
      end
    end
  end

  // Ticks arriving while a step is still being drained or published are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_miss_o <= '0;
    end else if (tick_i && (state != RUN) && (tick_miss_o != 8'hFF)) begin
      tick_miss_o <= tick_miss_o + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // DRAIN ends only once the FIFO is empty and the last weight has been added.
  always_comb begin
    next_state = state;
    case (state)
      RUN:     if (tick_i) next_state = DRAIN;
      DRAIN:   if (fifo_empty && !w_vld) next_state = PUB;
      PUB:     next_state = RUN;
      default: next_state = RUN;
    endcase
  end

endmodule

// File: tb/tb_synapse_current_driver.sv
// tb_synapse_current_driver
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic, all compared against a step-level behavioural model.
module tb_synapse_current_driver;

  localparam int N_PRE      = 16;
  localparam int WEIGHT_W   = 16;
  localparam int ACC_W      = 24;
  localparam int FIFO_DEPTH = 8;
  localparam int AW         = 4;

  logic                       clk;
  logic                       rst;
  logic                       ev_valid_i;
  logic                       ev_ready_o;
  logic [AW-1:0]              ev_addr_i;
  logic                       tick_i;
  logic                       wr_en_i;
  logic [AW-1:0]              wr_addr_i;
  logic signed [WEIGHT_W-1:0] wr_data_i;
  logic signed [WEIGHT_W-1:0] i_syn_o;
  logic                       step_o;
  logic                       sat_o;
  logic [7:0]                 tick_miss_o;

  int n_checks;
  int n_pass;

  // Model state: weights, weights of events accepted for the coming step,
  // whether a tick has been taken and not yet published, ignored tick count.
  longint m_w [N_PRE];
  longint pend_w [$];
  bit     step_pending;
  int     m_miss;
  longint prev_isyn;
  bit     prev_sat;
  bit     prev_step;

  synapse_current_driver #(
    .N_PRE      (N_PRE),
    .WEIGHT_W   (WEIGHT_W),
    .ACC_W      (ACC_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ev_valid_i  (ev_valid_i),
    .ev_ready_o  (ev_ready_o),
    .ev_addr_i   (ev_addr_i),
    .tick_i      (tick_i),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .i_syn_o     (i_syn_o),
    .step_o      (step_o),
    .sat_o       (sat_o),
    .tick_miss_o (tick_miss_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual == expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic longint clampTo(input longint v, input int width);
    longint lim;
    lim = longint'(1) <<< (width - 1);
    if (v > lim - 1) return lim - 1;
    if (v < -lim) return -lim;
    return v;
  endfunction

  // Drives one cycle of inputs at the falling edge.
  task automatic applyStimulus(input bit valid, input int addr, input bit tick,
                               input bit wr, input int wa, input int wd);
    @(negedge clk);
    ev_valid_i = valid;
    ev_addr_i  = addr[AW-1:0];
    tick_i     = tick;
    wr_en_i    = wr;
    wr_addr_i  = wa[AW-1:0];
    wr_data_i  = wd[WEIGHT_W-1:0];
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic writeWeight(input int a, input int d);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, a, d);
  endtask

  task automatic sendEvent(input int a);
    applyStimulus(1'b1, a, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic sendTick();
    applyStimulus(1'b0, 0, 1'b1, 1'b0, 0, 0);
  endtask

  // Waits (bounded) for the next step pulse, optionally holding an event offered.
  task automatic waitStep(input string name, input bit hv, input int ha, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      applyStimulus(hv, ha, 1'b0, 1'b0, 0, 0);
      if (step_o) begin
        seen = 1'b1;
      end else if (hv) begin
        checkOutput({name, "_ready_low"}, ev_ready_o, 0);
      end
    end
    checkOutput({name, "_step_seen"}, seen, 1);
  endtask

  // Monitor: inputs are captured just before each rising edge and outputs are
  // checked just after it against the step-level model.
  initial begin
    bit            c_rst, c_valid, c_ready, c_tick, c_wr;
    logic [AW-1:0] c_addr, c_wa;
    logic signed [WEIGHT_W-1:0] c_wd;
    longint s, t, o;
    bit     f;
    forever begin
      @(negedge clk);
      #2;
      c_rst   = rst;
      c_valid = ev_valid_i;
      c_ready = ev_ready_o;
      c_addr  = ev_addr_i;
      c_tick  = tick_i;
      c_wr    = wr_en_i;
      c_wa    = wr_addr_i;
      c_wd    = wr_data_i;
      if (!c_rst && step_pending) begin
        checkOutput("model_ready_low_in_step", ev_ready_o, 0);
      end
      @(posedge clk);
      #1;
      if (c_rst) begin
        foreach (m_w[i]) m_w[i] = 0;
        pend_w.delete();
        step_pending = 1'b0;
        m_miss       = 0;
        prev_isyn    = 0;
        prev_sat     = 1'b0;
        prev_step    = 1'b0;
        continue;
      end
      if (c_valid && c_ready) pend_w.push_back(m_w[c_addr]);
      if (c_tick) begin
        if (step_pending) begin
          if (m_miss < 255) m_miss++;
        end else begin
          step_pending = 1'b1;
        end
      end
      if (c_wr) m_w[c_wa] = c_wd;
      checkOutput("model_step_not_consecutive", step_o && prev_step, 0);
      if (step_o) begin
        checkOutput("model_step_expected", step_pending, 1);
        s = 0;
        f = 1'b0;
        foreach (pend_w[i]) begin
          t = s + pend_w[i];
          s = clampTo(t, ACC_W);
          if (s != t) f = 1'b1;
        end
        o = clampTo(s, WEIGHT_W);
        if (o != s) f = 1'b1;
        checkOutput("model_i_syn", i_syn_o, o);
        checkOutput("model_sat", sat_o, f);
        pend_w.delete();
        step_pending = 1'b0;
      end else begin
        checkOutput("model_i_syn_held", i_syn_o, prev_isyn);
        checkOutput("model_sat_held", sat_o, prev_sat);
      end
      checkOutput("model_tick_miss", tick_miss_o, m_miss);
      prev_isyn = i_syn_o;
      prev_sat  = sat_o;
      prev_step = step_o;
    end
  end

  initial begin
    bit seen;
    int pulses;
    int nw;
    int ncyc;
    int mode;
    int wd;
    n_checks   = 0;
    n_pass     = 0;
    rst        = 1'b1;
    ev_valid_i = 1'b0;
    ev_addr_i  = '0;
    tick_i     = 1'b0;
    wr_en_i    = 1'b0;
    wr_addr_i  = '0;
    wr_data_i  = '0;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", ev_ready_o, 0);
    checkOutput("rst_i_syn", i_syn_o, 0);
    checkOutput("rst_step", step_o, 0);
    checkOutput("rst_sat", sat_o, 0);
    checkOutput("rst_tick_miss", tick_miss_o, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("ready_after_reset", ev_ready_o, 1);

    // Basic sum: 100 + 100 - 30
    writeWeight(3, 100);
    writeWeight(5, -30);
    sendEvent(3);
    sendEvent(3);
    sendEvent(5);
    sendTick();
    waitStep("basic", 1'b0, 0, seen);
    checkOutput("basic_i_syn", i_syn_o, 170);
    checkOutput("basic_sat", sat_o, 0);

    // Empty step: pulse exactly between edges k+2 and k+3
    idle(2);
    sendTick();
    idle(1);
    checkOutput("empty_step_k1", step_o, 0);
    idle(1);
    checkOutput("empty_step_k2", step_o, 0);
    idle(1);
    checkOutput("empty_step_k3", step_o, 1);
    checkOutput("empty_i_syn", i_syn_o, 0);
    idle(1);
    checkOutput("empty_step_k4", step_o, 0);

    // Saturation: 4 x 32767 clamps on output, then clears
    writeWeight(0, 32767);
    repeat (4) sendEvent(0);
    sendTick();
    waitStep("sat", 1'b0, 0, seen);
    checkOutput("sat_i_syn", i_syn_o, 32767);
    checkOutput("sat_flag", sat_o, 1);
    idle(2);
    sendTick();
    waitStep("sat_clear", 1'b0, 0, seen);
    checkOutput("sat_clear_i_syn", i_syn_o, 0);
    checkOutput("sat_clear_flag", sat_o, 0);

    // Tick overrun: second tick lands in DRAIN
    idle(2);
    sendTick();
    sendTick();
    pulses = 0;
    repeat (10) begin
      idle(1);
      if (step_o) pulses++;
    end
    checkOutput("overrun_pulses", pulses, 1);
    checkOutput("overrun_tick_miss", tick_miss_o, 1);

    // Backpressure: event held across a tick is counted once in each step
    writeWeight(1, 10);
    applyStimulus(1'b1, 1, 1'b1, 1'b0, 0, 0);
    waitStep("bp", 1'b1, 1, seen);
    checkOutput("bp_first_i_syn", i_syn_o, 10);
    checkOutput("bp_ready_back", ev_ready_o, 1);
    idle(1);
    sendTick();
    waitStep("bp_next", 1'b0, 0, seen);
    checkOutput("bp_next_i_syn", i_syn_o, 10);

    // Reset in DRAIN with events in flight
    idle(2);
    writeWeight(2, 50);
    sendEvent(2);
    sendEvent(2);
    applyStimulus(1'b1, 2, 1'b1, 1'b0, 0, 0);
    @(negedge clk);
    rst        = 1'b1;
    ev_valid_i = 1'b0;
    tick_i     = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_ready", ev_ready_o, 0);
    checkOutput("mid_rst_i_syn", i_syn_o, 0);
    checkOutput("mid_rst_step", step_o, 0);
    checkOutput("mid_rst_sat", sat_o, 0);
    checkOutput("mid_rst_tick_miss", tick_miss_o, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    sendTick();
    waitStep("post_rst", 1'b0, 0, seen);
    checkOutput("post_rst_i_syn", i_syn_o, 0);
    checkOutput("post_rst_sat", sat_o, 0);

    // Randomized traffic
    for (int r = 0; r < 25; r++) begin
      nw = $urandom_range(1, 6);
      for (int k = 0; k < nw; k++) begin
        mode = $urandom_range(0, 3);
        if (mode == 0) wd = 32767;
        else if (mode == 1) wd = -32768;
        else wd = int'($signed(16'($urandom)));
        writeWeight($urandom_range(0, N_PRE - 1), wd);
      end
      ncyc = $urandom_range(5, 40);
      for (int k = 0; k < ncyc; k++) begin
        applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, N_PRE - 1),
                      ($urandom_range(0, 7) == 0), 1'b0, 0, 0);
      end
      idle(1);
      sendTick();
      waitStep("rand_a", 1'b0, 0, seen);
      idle(3);
      sendTick();
      waitStep("rand_b", 1'b0, 0, seen);
      idle(2);
    end

    idle(10);
    checkOutput("all_ticks_published", step_pending, 0);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
